game_sequencer: RTL and testbench
=================================

GAME_SEQUENCER -- requirements
Module: game_sequencer

Interface
REQ-001 Parameter NOTE_TICKS, default 25000000, clk cycles each challenge note is lit (minimum 1).
REQ-002 Parameter GAP_TICKS, default 12500000, clk cycles of dark LEDs after each challenge note (minimum 1).
REQ-003 Parameter WIN_TICKS, default 50000000, clk cycles spent in LEVEL_DONE (minimum 1).
REQ-004 Parameter TIMEOUT_TICKS, default 250000000, maximum clk cycles in WAIT_KEY before loss (minimum 1).
REQ-005 clk  input  1  single clock, all state on rising edge.
REQ-006 reset  input  1  asynchronous, active-low reset.
REQ-007 start  input  1  start/restart request, sampled each cycle.
REQ-008 keys  input  4  player note keys, active-high, already synchronized.
REQ-009 led_out  output  4  note LEDs.
REQ-010 state  output  4  current FSM state code, for the HEX display.
REQ-011 level  output  2  current level index 0..3.
REQ-012 score  output  8  notes answered correctly since last start.
REQ-013 game_won / game_lost  output  1 each  sticky end-of-game flags.

Function
REQ-014 The block SHALL hold an internal level ROM: L0 = 0001,0010,0100,1000 (len 4); L1 = 0001,0010,0010,0001 (len 4); L2 = 0100,0010,0001,0100 (len 4); L3 = 1000,0100,0001 (len 3). Notes are played first-listed first.
REQ-015 State codes SHALL be: IDLE=0, LOAD=1, PLAY_NOTE=2, PLAY_GAP=3, WAIT_KEY=4, CHECK=5, WAIT_RELEASE=6, LEVEL_DONE=7, WON=8, LOST=9. Codes 10..15 SHALL go to IDLE on the next cycle.
REQ-016 IDLE: leave only when start=1, going to LOAD with level=0 and score=0.
REQ-017 LOAD: one cycle; clear note index and timer; go to PLAY_NOTE.
REQ-018 PLAY_NOTE: led_out = ROM note[index] for exactly NOTE_TICKS cycles; then go to PLAY_GAP.
REQ-019 PLAY_GAP: led_out = 0 for exactly GAP_TICKS cycles. Afterwards, if index < len-1, increment index and return to PLAY_NOTE. Otherwise clear index and go to WAIT_KEY.
REQ-020 WAIT_KEY: led_out = keys. A press event is keys != 0 in this cycle with keys == 0 in the previous cycle; the previous-sample register SHALL update every cycle in every state. On a press event, capture keys and go to CHECK.
REQ-021 WAIT_KEY timeout: a counter cleared on entry SHALL go to LOST after TIMEOUT_TICKS cycles with no press event. A press on the final cycle wins over the timeout.
REQ-022 CHECK: one cycle, led_out = captured value.
  - Captured != ROM note[index] (including multi-hot): go to LOST.
  - Otherwise: increment index, increment score saturating at 255, go to WAIT_RELEASE.
REQ-023 WAIT_RELEASE: led_out = keys. When keys == 0: go to LEVEL_DONE if index == len, otherwise go to WAIT_KEY.
REQ-024 LEVEL_DONE: led_out = 4'b1111 for WIN_TICKS cycles. Then go to WON if level == 3; otherwise increment level and go to LOAD.
REQ-025 WON: game_won=1, led_out=1111. LOST: game_lost=1, led_out=0000. Both hold until start=1, which goes to LOAD with level=0, score=0, and both flags cleared.
REQ-026 start SHALL be ignored in all states except IDLE, WON and LOST.
REQ-027 Outputs SHALL be registered or decoded directly from registered state; keys SHALL NOT feed state, level, score or flag outputs combinationally.
REQ-028 Timers SHALL be 32-bit and SHALL count 0..N-1; a state with duration N lasts exactly N cycles.

Reset
REQ-029 While reset=0, regardless of clk:
  - state=IDLE; level=0; score=0; index=0; timers=0; previous-sample register=0.
  - led_out=0; game_won=0; game_lost=0.
REQ-030 Reset asserted mid-game SHALL abort to IDLE immediately. After release, no state change occurs without start.

Verification (NOTE_TICKS=2, GAP_TICKS=1, WIN_TICKS=3, TIMEOUT_TICKS=20)
REQ-031 Reset, start pulse -> state 1 for 1 cycle, then led_out 0001,0001,0000,0010,0010,0000,0100,0100,0000,1000,1000,0000, then state=4.
REQ-032 After the L0 playback, press and release 0001,0010,0100,1000 one at a time -> score=4, LEVEL_DONE for 3 cycles, level=1, state=1.
REQ-033 Complete all four levels correctly -> score=15, state=8, game_won=1, led_out=1111; then start -> level=0, score=0, game_won=0.
REQ-034 In WAIT_KEY of L0, press 0011 -> CHECK, then state=9, game_lost=1, score unchanged.
REQ-035 In WAIT_KEY, no key for 20 cycles -> state=9. Separately, a press on cycle 20 -> CHECK, not LOST.
REQ-036 Hold key 0001 from before WAIT_KEY entry -> no press event until it is released and pressed again. Also: assert reset during PLAY_NOTE -> state=0, led_out=0 within the same cycle.

Source files
------------

// File: rtl/game_sequencer.sv
// Note-memory game: plays each level's note pattern on the LEDs, then checks the
// player's key presses note by note, advancing through four levels to a win or a loss.
module game_sequencer #(
    parameter int unsigned NOTE_TICKS    = 25000000,
    parameter int unsigned GAP_TICKS     = 12500000,
    parameter int unsigned WIN_TICKS     = 50000000,
    parameter int unsigned TIMEOUT_TICKS = 250000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [3:0] keys,
    output logic [3:0] led_out,
    output logic [3:0] state,
    output logic [1:0] level,
    output logic [7:0] score,
    output logic       game_won,
    output logic       game_lost
);

    typedef enum logic [3:0] {
        S_IDLE         = 4'd0,
        S_LOAD         = 4'd1,
        S_PLAY_NOTE    = 4'd2,
        S_PLAY_GAP     = 4'd3,
        S_WAIT_KEY     = 4'd4,
        S_CHECK        = 4'd5,
        S_WAIT_RELEASE = 4'd6,
        S_LEVEL_DONE   = 4'd7,
        S_WON          = 4'd8,
        S_LOST         = 4'd9
    } state_e;

    localparam logic [31:0] NOTE_LAST    = NOTE_TICKS - 32'd1;
    localparam logic [31:0] GAP_LAST     = GAP_TICKS - 32'd1;
    localparam logic [31:0] WIN_LAST     = WIN_TICKS - 32'd1;
    localparam logic [31:0] TIMEOUT_LAST = TIMEOUT_TICKS - 32'd1;

    state_e      state_q, state_d;
    logic [1:0]  level_q, level_d;
    logic [7:0]  score_q, score_d;
    logic [2:0]  index_q, index_d;
    logic [31:0] timer_q, timer_d;
    logic [3:0]  cap_q, cap_d;
    logic [3:0]  prev_keys_q;

    logic [2:0]  level_len;
    logic [3:0]  cur_note;
    logic        press;

    function automatic logic [3:0] rom_note(input logic [1:0] lvl, input logic [1:0] idx);
        logic [3:0] n;
        case ({lvl, idx})
            4'b00_00: n = 4'b0001;
            4'b00_01: n = 4'b0010;
            4'b00_10: n = 4'b0100;
            4'b00_11: n = 4'b1000;
            4'b01_00: n = 4'b0001;
            4'b01_01: n = 4'b0010;
            4'b01_10: n = 4'b0010;
            4'b01_11: n = 4'b0001;
            4'b10_00: n = 4'b0100;
            4'b10_01: n = 4'b0010;
            4'b10_10: n = 4'b0001;
            4'b10_11: n = 4'b0100;
            4'b11_00: n = 4'b1000;
            4'b11_01: n = 4'b0100;
            4'b11_10: n = 4'b0001;
            default:  n = 4'b0000;
        endcase
        return n;
    endfunction

    assign level_len = (level_q == 2'd3) ? 3'd3 : 3'd4;
    assign cur_note  = rom_note(level_q, index_q[1:0]);
    // A press is a rising edge of "any key down", so a key held across states never counts.
    assign press     = (keys != 4'b0000) && (prev_keys_q == 4'b0000);

    always_comb begin
        state_d = state_q;
        level_d = level_q;
        score_d = score_q;
        index_d = index_q;
        timer_d = timer_q;
        cap_d   = cap_q;
        led_out = 4'b0000;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_LOAD;
                    level_d = 2'd0;
                    score_d = 8'd0;
                end
            end
            S_LOAD: begin
                index_d = 3'd0;
                timer_d = 32'd0;
                state_d = S_PLAY_NOTE;
            end
            S_PLAY_NOTE: begin
                led_out = cur_note;
                if (timer_q == NOTE_LAST) begin
                    timer_d = 32'd0;
                    state_d = S_PLAY_GAP;
                end else begin
                    timer_d = timer_q + 32'd1;
                end
            end
            S_PLAY_GAP: begin
                if (timer_q == GAP_LAST) begin
                    timer_d = 32'd0;
                    if (index_q < level_len - 3'd1) begin
                        index_d = index_q + 3'd1;
                        state_d = S_PLAY_NOTE;
                    end else begin
                        index_d = 3'd0;
                        state_d = S_WAIT_KEY;
                    end
                end else begin
                    timer_d = timer_q + 32'd1;
                end
            end
            S_WAIT_KEY: begin
                led_out = keys;
                if (press) begin
                    cap_d   = keys;
                    timer_d = 32'd0;
                    state_d = S_CHECK;
                end else if (timer_q == TIMEOUT_LAST) begin
                    timer_d = 32'd0;
                    state_d = S_LOST;
                end else begin
                    timer_d = timer_q + 32'd1;
                end
            end
            S_CHECK: begin
                led_out = cap_q;
                if (cap_q != cur_note) begin
                    state_d = S_LOST;
                end else begin
                    index_d = index_q + 3'd1;
                    if (score_q != 8'hFF) score_d = score_q + 8'd1;
                    state_d = S_WAIT_RELEASE;
                end
            end
            S_WAIT_RELEASE: begin
                led_out = keys;
                if (keys == 4'b0000) begin
                    timer_d = 32'd0;
                    state_d = (index_q == level_len) ? S_LEVEL_DONE : S_WAIT_KEY;
                end
            end
            S_LEVEL_DONE: begin
                led_out = 4'b1111;
                if (timer_q == WIN_LAST) begin
                    timer_d = 32'd0;
                    if (level_q == 2'd3) begin
                        state_d = S_WON;
                    end else begin
                        level_d = level_q + 2'd1;
                        state_d = S_LOAD;
                    end
                end else begin
                    timer_d = timer_q + 32'd1;
                end
            end
            S_WON, S_LOST: begin
                led_out = (state_q == S_WON) ? 4'b1111 : 4'b0000;
                if (start) begin
                    state_d = S_LOAD;
                    level_d = 2'd0;
                    score_d = 8'd0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            level_q     <= 2'd0;
            score_q     <= 8'd0;
            index_q     <= 3'd0;
            timer_q     <= 32'd0;
            cap_q       <= 4'd0;
            prev_keys_q <= 4'd0;
        end else begin
            state_q     <= state_d;
            level_q     <= level_d;
            score_q     <= score_d;
            index_q     <= index_d;
            timer_q     <= timer_d;
            cap_q       <= cap_d;
            prev_keys_q <= keys;
        end
    end

    // The end-of-game flags are just the terminal states, so they clear when start leaves them.
    assign state     = state_q;
    assign level     = level_q;
    assign score     = score_q;
    assign game_won  = (state_q == S_WON);
    assign game_lost = (state_q == S_LOST);

endmodule

// File: tb/tb_game_sequencer.sv
// Bench for game_sequencer: a vector table walks the first level cycle by cycle, then
// scripted and randomized games are checked against a note-by-note model of play.
module tb_game_sequencer;

    localparam int NT = 2;
    localparam int GT = 1;
    localparam int WT = 3;
    localparam int TT = 20;

    localparam int ST_IDLE  = 0;
    localparam int ST_LOAD  = 1;
    localparam int ST_NOTE  = 2;
    localparam int ST_GAP   = 3;
    localparam int ST_WAIT  = 4;
    localparam int ST_CHECK = 5;
    localparam int ST_REL   = 6;
    localparam int ST_DONE  = 7;
    localparam int ST_WON   = 8;
    localparam int ST_LOST  = 9;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [3:0] keys;
    logic [3:0] led_out;
    logic [3:0] state;
    logic [1:0] level;
    logic [7:0] score;
    logic       game_won;
    logic       game_lost;

    game_sequencer #(
        .NOTE_TICKS(NT), .GAP_TICKS(GT), .WIN_TICKS(WT), .TIMEOUT_TICKS(TT)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .keys(keys),
        .led_out(led_out), .state(state), .level(level), .score(score),
        .game_won(game_won), .game_lost(game_lost)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       st;
        logic [3:0] k;
        int         expState;
        logic [3:0] expLed;
        int         expLevel;
        int         expScore;
    } vec_t;

    vec_t vecs[$];
    int   total = 0;
    int   bad = 0;
    int   expScore = 0;
    int   lastState = ST_IDLE;
    bit   allowMistakes = 1'b0;

    function automatic logic [3:0] noteOf(input int lv, input int ix);
        logic [3:0] pat [4][4];
        pat = '{'{4'h1, 4'h2, 4'h4, 4'h8}, '{4'h1, 4'h2, 4'h2, 4'h1},
                '{4'h4, 4'h2, 4'h1, 4'h4}, '{4'h8, 4'h4, 4'h1, 4'h0}};
        return pat[lv][ix];
    endfunction

    function automatic int lenOf(input int lv);
        return (lv == 3) ? 3 : 4;
    endfunction

    function automatic void addVec(input logic st, input logic [3:0] k, input int s,
                                   input logic [3:0] l, input int lv, input int sc);
        vec_t v;
        v.st = st; v.k = k; v.expState = s; v.expLed = l; v.expLevel = lv; v.expScore = sc;
        vecs.push_back(v);
    endfunction

    task automatic checkOutput(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Advance one clock edge on the previous inputs, then present new inputs for the next edge.
    task automatic applyStimulus(input logic st, input logic [3:0] k);
        @(posedge clk);
        #1;
        start = st;
        keys  = k;
        #1;
    endtask

    task automatic startGame(input int fromState);
        applyStimulus(1'b1, 4'h0);
        checkOutput("preStart.state", int'(state), fromState);
        applyStimulus(1'b0, 4'h0);
        checkOutput("start.state", int'(state), ST_LOAD);
        checkOutput("start.level", int'(level), 0);
        checkOutput("start.score", int'(score), 0);
        checkOutput("start.won", int'(game_won), 0);
        checkOutput("start.lost", int'(game_lost), 0);
        expScore = 0;
    endtask

    task automatic expectPlayback(input int lv, input logic [3:0] held);
        for (int ix = 0; ix < lenOf(lv); ix++) begin
            for (int c = 0; c < NT; c++) begin
                applyStimulus(1'b0, held);
                checkOutput("note.state", int'(state), ST_NOTE);
                checkOutput("note.led", int'(led_out), int'(noteOf(lv, ix)));
            end
            for (int c = 0; c < GT; c++) begin
                applyStimulus(1'b0, held);
                checkOutput("gap.state", int'(state), ST_GAP);
                checkOutput("gap.led", int'(led_out), 0);
            end
        end
        applyStimulus(1'b0, held);
        checkOutput("waitEntry.state", int'(state), ST_WAIT);
        checkOutput("waitEntry.led", int'(led_out), int'(held));
        checkOutput("waitEntry.level", int'(level), lv);
    endtask

    // Press k on WAIT_KEY cycle p (cycle 0 is entry); p >= TT means the player never presses.
    task automatic answerNote(input int lv, input int ix, input int p, input logic [3:0] k,
                              input int hold, output bit lost);
        logic [3:0] n;
        n = noteOf(lv, ix);
        lost = 1'b0;
        for (int c = 1; c < p && c < TT; c++) begin
            applyStimulus(1'b0, 4'h0);
            checkOutput("waitIdle.state", int'(state), ST_WAIT);
        end
        if (p >= TT) begin
            applyStimulus(1'b0, 4'h0);
            checkOutput("timeout.state", int'(state), ST_LOST);
            checkOutput("timeout.lost", int'(game_lost), 1);
            checkOutput("timeout.led", int'(led_out), 0);
            lost = 1'b1;
            return;
        end
        applyStimulus(1'b0, k);
        checkOutput("press.state", int'(state), ST_WAIT);
        checkOutput("press.led", int'(led_out), int'(k));
        applyStimulus(1'b0, k);
        checkOutput("check.state", int'(state), ST_CHECK);
        checkOutput("check.led", int'(led_out), int'(k));
        if (k != n) begin
            applyStimulus(1'b0, 4'h0);
            checkOutput("wrong.state", int'(state), ST_LOST);
            checkOutput("wrong.lost", int'(game_lost), 1);
            checkOutput("wrong.score", int'(score), expScore);
            lost = 1'b1;
            return;
        end
        expScore = (expScore < 255) ? expScore + 1 : 255;
        for (int h = 0; h < hold; h++) begin
            applyStimulus(1'b0, k);
            checkOutput("hold.state", int'(state), ST_REL);
            checkOutput("hold.led", int'(led_out), int'(k));
        end
        applyStimulus(1'b0, 4'h0);
        checkOutput("release.state", int'(state), ST_REL);
        checkOutput("release.score", int'(score), expScore);
    endtask

    task automatic playLevel(input int lv, input int fp, input logic [3:0] fk, output bit lost);
        int         p;
        logic [3:0] k;
        int         r;
        lost = 1'b0;
        expectPlayback(lv, 4'h0);
        for (int ix = 0; ix < lenOf(lv); ix++) begin
            p = int'($urandom_range(1, TT - 1));
            k = noteOf(lv, ix);
            if (ix == 0 && fp > 0) begin
                p = fp;
                k = fk;
            end else if (allowMistakes) begin
                r = int'($urandom_range(0, 19));
                if (r == 0) p = TT;
                if (r == 1) begin
                    do k = 4'($urandom_range(1, 15)); while (k == noteOf(lv, ix));
                end
            end
            answerNote(lv, ix, p, k, int'($urandom_range(0, 2)), lost);
            if (lost) return;
            applyStimulus(1'b0, 4'h0);
            if (ix < lenOf(lv) - 1) begin
                checkOutput("nextKey.state", int'(state), ST_WAIT);
            end else begin
                checkOutput("done.state", int'(state), ST_DONE);
                checkOutput("done.led", int'(led_out), 15);
            end
        end
        for (int c = 1; c < WT; c++) begin
            applyStimulus(1'b0, 4'h0);
            checkOutput("done.state", int'(state), ST_DONE);
        end
        applyStimulus(1'b0, 4'h0);
        if (lv == 3) begin
            checkOutput("won.state", int'(state), ST_WON);
            checkOutput("won.flag", int'(game_won), 1);
            checkOutput("won.led", int'(led_out), 15);
            checkOutput("won.score", int'(score), expScore);
        end else begin
            checkOutput("nextLevel.state", int'(state), ST_LOAD);
            checkOutput("nextLevel.level", int'(level), lv + 1);
        end
    endtask

    task automatic playGame(input int fromState, input int fp, input logic [3:0] fk);
        bit lost;
        lost = 1'b0;
        startGame(fromState);
        for (int lv = 0; lv < 4 && !lost; lv++) playLevel(lv, (lv == 0) ? fp : 0, fk, lost);
        lastState = lost ? ST_LOST : ST_WON;
    endtask

    initial begin
        bit lost;
        reset = 1'b0;
        start = 1'b0;
        keys  = 4'h0;

        // First level walked cycle by cycle: start, playback, four correct presses, level done.
        addVec(1'b1, 4'h0, ST_IDLE, 4'h0, 0, 0);
        addVec(1'b0, 4'h0, ST_LOAD, 4'h0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            addVec(1'b0, 4'h0, ST_NOTE, noteOf(0, i), 0, 0);
            addVec(1'b0, 4'h0, ST_NOTE, noteOf(0, i), 0, 0);
            addVec(1'b0, 4'h0, ST_GAP, 4'h0, 0, 0);
        end
        addVec(1'b0, 4'h0, ST_WAIT, 4'h0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            addVec(1'b0, noteOf(0, i), ST_WAIT, noteOf(0, i), 0, i);
            addVec(1'b0, noteOf(0, i), ST_CHECK, noteOf(0, i), 0, i);
            addVec(1'b0, 4'h0, ST_REL, 4'h0, 0, i + 1);
            if (i < 3) addVec(1'b0, 4'h0, ST_WAIT, 4'h0, 0, i + 1);
        end
        for (int i = 0; i < 3; i++) addVec(1'b0, 4'h0, ST_DONE, 4'hF, 0, 4);
        addVec(1'b0, 4'h0, ST_LOAD, 4'h0, 1, 4);

        #11;
        keys = 4'hF;
        #1;
        checkOutput("rst.state", int'(state), ST_IDLE);
        checkOutput("rst.led", int'(led_out), 0);
        checkOutput("rst.level", int'(level), 0);
        checkOutput("rst.score", int'(score), 0);
        checkOutput("rst.won", int'(game_won), 0);
        checkOutput("rst.lost", int'(game_lost), 0);
        keys = 4'h0;
        #1;
        reset = 1'b1;

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].st, vecs[i].k);
            checkOutput($sformatf("vec%0d.state", i), int'(state), vecs[i].expState);
            checkOutput($sformatf("vec%0d.led", i), int'(led_out), int'(vecs[i].expLed));
            checkOutput($sformatf("vec%0d.level", i), int'(level), vecs[i].expLevel);
            checkOutput($sformatf("vec%0d.score", i), int'(score), vecs[i].expScore);
        end

        // Finish the remaining levels without mistakes.
        expScore = 4;
        lost = 1'b0;
        for (int lv = 1; lv < 4 && !lost; lv++) playLevel(lv, 0, 4'h0, lost);
        checkOutput("fullGame.lost", int'(lost), 0);
        checkOutput("fullGame.score", int'(score), 15);
        checkOutput("fullGame.won", int'(game_won), 1);
        lastState = ST_WON;

        playGame(lastState, 3, 4'b0011);
        checkOutput("multiHot.endState", lastState, ST_LOST);
        playGame(lastState, TT, 4'h0);
        checkOutput("timeout.endState", lastState, ST_LOST);
        playGame(lastState, TT - 1, 4'h1);
        checkOutput("lastCyclePress.endState", lastState, ST_WON);

        // Key held since playback must be released and pressed again to count.
        startGame(lastState);
        expectPlayback(0, 4'h1);
        repeat (3) begin
            applyStimulus(1'b0, 4'h1);
            checkOutput("heldNoPress.state", int'(state), ST_WAIT);
        end
        applyStimulus(1'b0, 4'h0);
        checkOutput("heldRelease.state", int'(state), ST_WAIT);
        applyStimulus(1'b0, 4'h1);
        checkOutput("repress.state", int'(state), ST_WAIT);
        applyStimulus(1'b0, 4'h1);
        checkOutput("repress.check", int'(state), ST_CHECK);
        applyStimulus(1'b0, 4'h0);
        checkOutput("repress.score", int'(score), 1);

        // Asynchronous abort from the middle of a note.
        reset = 1'b0;
        #1;
        reset = 1'b1;
        startGame(ST_IDLE);
        applyStimulus(1'b0, 4'h0);
        checkOutput("preAbort.state", int'(state), ST_NOTE);
        reset = 1'b0;
        #1;
        checkOutput("abort.state", int'(state), ST_IDLE);
        checkOutput("abort.led", int'(led_out), 0);
        applyStimulus(1'b0, 4'h0);
        checkOutput("abortHeld.state", int'(state), ST_IDLE);
        reset = 1'b1;
        repeat (3) begin
            applyStimulus(1'b0, 4'h3);
            checkOutput("postAbort.state", int'(state), ST_IDLE);
        end
        lastState = ST_IDLE;

        allowMistakes = 1'b1;
        repeat (8) playGame(lastState, 0, 4'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
